pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised elastic pipeline-stage register for the five-stage processor. It replaces the fixed 49-bit stall/flush latch between stages. It carries a generic WIDTH payload with valid/ready handshaking and keeps the legacy stall and flush controls. An optional second skid entry lets in_ready be driven from a register. A saturating stall-cycle counter supports hazard-unit tuning.

## Interface
- WIDTH, 49: payload width in bits.
- NOP_WORD, 49'h0_0000_0000_E200: payload loaded on reset, on flush and when the stage empties; the decode of a bubble.
- SKID, 1: 1 gives a 2-entry buffer with registered in_ready; 0 gives a 1-entry buffer with combinational in_ready.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous kill of all buffered entries; priority over everything, including reset.
- stall  in  1  hazard hold; while 1 the output entry is not consumed, equivalent to out_ready=0.
- in_valid  in  1  upstream entry present.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  stage can accept this cycle.
- out_valid  out  1  out_data holds a real entry.
- out_data  out  WIDTH  head entry; equals NOP_WORD when out_valid=0.
- out_ready  in  1  downstream consumes.
- count  out  2  occupancy, 0..2.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and no drain.

## Operation
- accept = in_valid & in_ready; drain = out_valid & out_ready & ~stall.
- Storage: main register M (drives out_data/out_valid); skid register S (exists only when SKID=1).
- States (SKID=1): EMPTY (count 0), ONE (count 1), TWO (count 2).
  - EMPTY: on accept, M<=in_data and go to ONE; otherwise stay EMPTY.
  - ONE, accept & drain: M<=in_data, stay ONE.
  - ONE, accept & ~drain: S<=in_data, go to TWO.
  - ONE, drain & ~accept: M<=NOP_WORD, go to EMPTY.
  - ONE, neither: hold.
  - TWO: on drain, M<=S, S<=NOP_WORD, go to ONE; otherwise hold. No accept is possible in TWO.
- in_ready (SKID=1) = registered (next state != TWO). It never depends on out_ready or stall in the same cycle.
- SKID=0: only EMPTY and ONE exist. in_ready = ~out_valid | drain (combinational). Transitions are as above, with no TWO state.
- Ordering is strictly FIFO. An entry is never duplicated or dropped except by flush.
- flush=1 at an edge:
  - M<=NOP_WORD and S<=NOP_WORD; go to EMPTY; in_ready becomes 1.
  - Any simultaneous accept is discarded, and the in-flight input is not stored.
  - stall_cnt is unaffected.
- reset=1 (flush=0): same state effect as flush, and stall_cnt<=0.
- stall_cnt increments when out_valid & ~drain. It saturates at 2^CNT_W-1 and never wraps.
- X on stall is treated as 1 (hold).

## Timing
- Reset values: out_valid=0, out_data=NOP_WORD, in_ready=1, count=0, stall_cnt=0.
- Latency: an entry accepted at edge N is on out_data with out_valid=1 after edge N (first visible in cycle N+1), when the stage was empty.
- Throughput: 1 entry/cycle when out_ready=1 and stall=0, in both SKID modes.
- SKID=1 backpressure: after out stops consuming, at most one more entry is accepted (into S), then in_ready=0 from the next cycle.
- After flush or reset: the first accept is possible in the cycle right after the edge.
- Simultaneous flush and reset: flush behaviour applies, and stall_cnt still clears because reset=1.
- Reset or flush mid-transfer aborts the transfer; nothing partial remains in M or S.

## Test plan
- Reset: reset=1 for 2 cycles -> out_valid=0, out_data=49'hE200, in_ready=1, count=0, stall_cnt=0.
- Streaming (SKID=1): in_data 1,2,3,4 in consecutive cycles, out_ready=1 -> out_data 1,2,3,4 on the following cycles with 1-cycle latency and no bubbles; count stays 1.
- Skid fill: send 0xA then 0xB, out_ready=0 from the start -> count=2 and in_ready=0 next cycle. Raise out_ready -> 0xA, then 0xB, then out_valid=0 with out_data=NOP_WORD.
- Stall: in count=1 with out_ready=1, hold stall=1 for 5 cycles -> out_data unchanged and stall_cnt=5. Release -> entry drains.
- Flush with full buffer: count=2 plus in_valid=1 and flush=1 -> next cycle count=0, out_valid=0, out_data=NOP_WORD, in_ready=1, and the input is not stored.
- SKID=0 with CNT_W=2:
  - Stall for 6 cycles -> stall_cnt saturates at 3.
  - in_ready follows out_ready combinationally while full.

Source files
------------

// File: rtl/pipe_stage_if.sv
// Handshake bundle between pipeline stages: upstream input side and downstream output side.
interface pipe_stage_if #(
  parameter int WIDTH = 49
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with legacy stall/flush, optional skid entry
// for a registered in_ready, and a saturating stall-cycle counter.
module pipe_stage_buf #(
  parameter int               WIDTH    = 49,
  parameter logic [WIDTH-1:0] NOP_WORD = 49'h0_0000_0000_E200,
  parameter int               SKID     = 1,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  pipe_stage_if.slave      bus,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_r, state_n;
  logic [WIDTH-1:0]   m_r, m_n;
  logic [WIDTH-1:0]   s_r, s_n;
  logic               in_ready_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic               hold_s;
  logic               out_valid_s;
  logic               drain_s;
  logic               accept_s;
  logic               in_ready_comb_s;
  logic               stall_inc_s;

  // An unknown stall is treated as a hold so a bad hazard signal never loses an entry
  always_comb begin
    case (stall)
      1'b0:    hold_s = 1'b0;
      default: hold_s = 1'b1;
    endcase
  end

  assign out_valid_s     = (state_r != EMPTY);
  assign drain_s         = out_valid_s & bus.out_ready & ~hold_s;
  assign in_ready_comb_s = ~out_valid_s | drain_s;
  assign accept_s        = bus.in_valid & bus.in_ready;

  assign bus.in_ready  = (SKID != 0) ? in_ready_r : in_ready_comb_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = m_r;
  assign stall_cnt     = stall_cnt_r;

  // Next-state and storage update; flush/reset override any transfer in flight
  always_comb begin
    state_n = state_r;
    m_n     = m_r;
    s_n     = s_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          m_n     = bus.in_data;
          state_n = ONE;
        end else begin
          state_n = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && drain_s) begin
          m_n = bus.in_data;
        end else if (accept_s) begin
          s_n     = bus.in_data;
          state_n = TWO;
        end else if (drain_s) begin
          m_n     = NOP_WORD;
          state_n = EMPTY;
        end else begin
          state_n = ONE;
        end
      end
      TWO: begin
        if (drain_s) begin
          m_n     = s_r;
          s_n     = NOP_WORD;
          state_n = ONE;
        end else begin
          state_n = TWO;
        end
      end
      default: begin
        m_n     = NOP_WORD;
        s_n     = NOP_WORD;
        state_n = EMPTY;
      end
    endcase
    if (flush || reset) begin
      m_n     = NOP_WORD;
      s_n     = NOP_WORD;
      state_n = EMPTY;
    end else begin
      state_n = state_n;
    end
  end

  // State and payload registers
  always_ff @(posedge clk) begin
    state_r    <= state_n;
    m_r        <= m_n;
    s_r        <= s_n;
    in_ready_r <= (state_n != TWO);
  end

  assign stall_inc_s = out_valid_s & ~drain_s & (stall_cnt_r != {CNT_W{1'b1}});

  // Stall counter: only reset clears it, flush leaves it alone
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_inc_s) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Occupancy decode
  always_comb begin
    case (state_r)
      EMPTY:   count = 2'd0;
      ONE:     count = 2'd1;
      TWO:     count = 2'd2;
      default: count = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a SKID=1/CNT_W=16 and a SKID=0/CNT_W=2 instance share stimulus
// and are checked every cycle against a queue model, plus directed literal checks.
module tb_pipe_stage_buf;
  localparam int W = 49;
  localparam logic [W-1:0] NOP = 49'h0_0000_0000_E200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1, flush = 1'b0, stall = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  int checks = 0;
  int failures = 0;

  pipe_stage_if #(.WIDTH(W)) bs ();
  pipe_stage_if #(.WIDTH(W)) bn ();

  assign bs.in_valid = in_valid;
  assign bs.in_data = in_data;
  assign bs.out_ready = out_ready;
  assign bn.in_valid = in_valid;
  assign bn.in_data = in_data;
  assign bn.out_ready = out_ready;

  logic [1:0]  cnt_s, cnt_n;
  logic [15:0] sc_s;
  logic [1:0]  sc_n;

  pipe_stage_buf #(.WIDTH(W), .NOP_WORD(NOP), .SKID(1), .CNT_W(16)) dut_s (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .bus(bs), .count(cnt_s), .stall_cnt(sc_s)
  );

  pipe_stage_buf #(.WIDTH(W), .NOP_WORD(NOP), .SKID(0), .CNT_W(2)) dut_n (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .bus(bn), .count(cnt_n), .stall_cnt(sc_n)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: index 0 is the skid instance, index 1 the non-skid one
  logic [W-1:0] mq [2][2];
  int           msz [2];
  int           mcnt [2];
  int           mmax [2];

  initial begin
    msz[0] = 0; msz[1] = 0;
    mcnt[0] = 0; mcnt[1] = 0;
    mmax[0] = 65535; mmax[1] = 3;
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        logic         drn, rdy, acc;
        logic         a_ov, a_ir;
        logic [W-1:0] a_od;
        logic [1:0]   a_cnt;
        logic [15:0]  a_sc;
        drn = (msz[k] > 0) && out_ready && (stall === 1'b0);
        rdy = (k == 0) ? (msz[k] < 2) : ((msz[k] == 0) || drn);
        acc = in_valid && rdy;
        a_ov  = (k == 0) ? bs.out_valid : bn.out_valid;
        a_ir  = (k == 0) ? bs.in_ready  : bn.in_ready;
        a_od  = (k == 0) ? bs.out_data  : bn.out_data;
        a_cnt = (k == 0) ? cnt_s : cnt_n;
        a_sc  = (k == 0) ? sc_s : {14'd0, sc_n};
        chk($sformatf("m%0d_out_valid", k), 64'(a_ov), 64'(msz[k] > 0));
        chk($sformatf("m%0d_out_data", k), 64'(a_od), (msz[k] > 0) ? 64'(mq[k][0]) : 64'(NOP));
        chk($sformatf("m%0d_count", k), 64'(a_cnt), 64'(msz[k]));
        chk($sformatf("m%0d_in_ready", k), 64'(a_ir), 64'(rdy));
        chk($sformatf("m%0d_stall_cnt", k), 64'(a_sc), 64'(mcnt[k]));
        if ((msz[k] > 0) && !drn && (mcnt[k] < mmax[k])) mcnt[k]++;
        if (reset) mcnt[k] = 0;
        if (reset || flush) begin
          msz[k] = 0;
        end else begin
          if (drn) begin
            mq[k][0] = mq[k][1];
            msz[k]--;
          end
          if (acc) begin
            mq[k][msz[k]] = in_data;
            msz[k]++;
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] r;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bs.out_valid), 64'd0);
    chk("rst_out_data", 64'(bs.out_data), 64'h0000_0000_0000_E200);
    chk("rst_in_ready", 64'(bs.in_ready), 64'd1);
    chk("rst_count", 64'(cnt_s), 64'd0);
    chk("rst_stall_cnt", 64'(sc_s), 64'd0);

    // Streaming 1..4
    reset = 1'b0; in_valid = 1'b1; in_data = 49'd1; out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      chk("stream_data", 64'(bs.out_data), 64'(i - 1));
      chk("stream_count", 64'(cnt_s), 64'd1);
      if (i <= 4) in_data = 49'(i);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    chk("stream_tail_valid", 64'(bs.out_valid), 64'd0);

    // Skid fill with out_ready low
    out_ready = 1'b0; in_valid = 1'b1; in_data = 49'hA;
    @(negedge clk);
    in_data = 49'hB;
    @(negedge clk);
    chk("skid_count", 64'(cnt_s), 64'd2);
    chk("skid_in_ready", 64'(bs.in_ready), 64'd0);
    chk("skid_head", 64'(bs.out_data), 64'hA);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("skid_second", 64'(bs.out_data), 64'hB);
    @(negedge clk);
    chk("skid_empty_valid", 64'(bs.out_valid), 64'd0);
    chk("skid_empty_data", 64'(bs.out_data), 64'(NOP));

    // Stall hold and counter saturation
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b1; in_data = 49'h55; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; stall = 1'b1;
    repeat (5) @(negedge clk);
    chk("stall_cnt5", 64'(sc_s), 64'd5);
    chk("stall_hold_data", 64'(bs.out_data), 64'h55);
    chk("stall_noskid_in_ready", 64'(bn.in_ready), 64'd0);
    @(negedge clk);
    chk("stall_cnt6", 64'(sc_s), 64'd6);
    chk("stall_sat", 64'(sc_n), 64'd3);
    stall = 1'b0; out_ready = 1'b1;
    #2;
    chk("comb_ready_hi", 64'(bn.in_ready), 64'd1);
    out_ready = 1'b0;
    #1;
    chk("comb_ready_lo", 64'(bn.in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 64'(bs.out_valid), 64'd0);

    // Flush with full buffer and an input offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 49'hC1;
    @(negedge clk);
    in_data = 49'hC2;
    @(negedge clk);
    chk("flush_pre_count", 64'(cnt_s), 64'd2);
    in_data = 49'hC3; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 64'(cnt_s), 64'd0);
    chk("flush_valid", 64'(bs.out_valid), 64'd0);
    chk("flush_data", 64'(bs.out_data), 64'(NOP));
    chk("flush_in_ready", 64'(bs.in_ready), 64'd1);
    @(negedge clk);
    chk("flush_not_stored", 64'(bs.out_valid), 64'd0);

    // Flush together with reset still clears the stall counter
    in_valid = 1'b1; in_data = 49'hD1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1; reset = 1'b1;
    @(negedge clk);
    flush = 1'b0; reset = 1'b0;
    chk("flush_reset_cnt", 64'(sc_s), 64'd0);
    chk("flush_reset_count", 64'(cnt_s), 64'd0);

    // Random traffic
    repeat (3000) begin
      @(negedge clk);
      r = {$urandom, $urandom};
      in_data   = r[W-1:0];
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      stall     = ($urandom % 8) == 0;
      flush     = ($urandom % 50) == 0;
      reset     = ($urandom % 80) == 0;
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0; stall = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
